// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: bubble (clr), freeze (en=0) and Tnew aging for the EX stage.
// Optional bubble counter is compiled in when IDEX_BUBBLE_CNT_EN is defined.
module id_ex_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned TNEW_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [31:0]       d_instr,
  input  logic [31:0]       d_pc,
  input  logic [31:0]       d_rs_data,
  input  logic [31:0]       d_rt_data,
  input  logic [31:0]       d_ext,
  input  logic [4:0]        d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  output logic [31:0]       e_instr,
  output logic [31:0]       e_pc,
  output logic [31:0]       e_pc8,
  output logic [31:0]       e_rs_data,
  output logic [31:0]       e_rt_data,
  output logic [31:0]       e_ext,
  output logic [4:0]        e_rs_addr,
  output logic [4:0]        e_rt_addr,
  output logic [4:0]        e_a3,
  output logic [TNEW_W-1:0] e_tnew,
`ifdef IDEX_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt,
`endif
  output logic              e_valid
);

  function automatic logic [TNEW_W-1:0] tnew_sat_dec(input logic [TNEW_W-1:0] t);
    if (t == '0) return '0;
    return t - TNEW_W'(1);
  endfunction

  function automatic logic [31:0] pc_link(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc_q,    pc_d;
  logic [31:0]       rs_q,    rs_d;
  logic [31:0]       rt_q,    rt_d;
  logic [31:0]       ext_q,   ext_d;
  logic [4:0]        a3_q,    a3_d;
  logic [TNEW_W-1:0] tnew_q,  tnew_d;
  logic              valid_q, valid_d;

  // A bubble keeps its slot PC but carries no destination, so hazard logic stays quiet.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    ext_d   = ext_q;
    a3_d    = a3_q;
    tnew_d  = tnew_q;
    valid_d = valid_q;
    if (clr) begin
      instr_d = '0;
      pc_d    = d_pc;
      rs_d    = '0;
      rt_d    = '0;
      ext_d   = '0;
      a3_d    = '0;
      tnew_d  = '0;
      valid_d = 1'b0;
    end else if (en) begin
      instr_d = d_instr;
      pc_d    = d_pc;
      rs_d    = d_rs_data;
      rt_d    = d_rt_data;
      ext_d   = d_ext;
      a3_d    = d_a3;
      tnew_d  = tnew_sat_dec(d_tnew);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= PC_RESET;
      rs_q    <= '0;
      rt_q    <= '0;
      ext_q   <= '0;
      a3_q    <= '0;
      tnew_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      ext_q   <= ext_d;
      a3_q    <= a3_d;
      tnew_q  <= tnew_d;
      valid_q <= valid_d;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (clr) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) bubble_cnt_q <= '0;
    else       bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign e_instr   = instr_q;
  assign e_pc      = pc_q;
  assign e_pc8     = pc_link(pc_q);
  assign e_rs_data = rs_q;
  assign e_rt_data = rt_q;
  assign e_ext     = ext_q;
  assign e_rs_addr = instr_q[25:21];
  assign e_rt_addr = instr_q[20:16];
  assign e_a3      = a3_q;
  assign e_tnew    = tnew_q;
  assign e_valid   = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg (bubble counter checks need IDEX_BUBBLE_CNT_EN).
module tb_id_ex_reg;
  logic        clk = 1'b0;
  logic        reset, clr, en;
  logic [31:0] d_instr, d_pc, d_rs_data, d_rt_data, d_ext;
  logic [4:0]  d_a3;
  logic [1:0]  d_tnew;
  logic [31:0] e_instr, e_pc, e_pc8, e_rs_data, e_rt_data, e_ext;
  logic [4:0]  e_rs_addr, e_rt_addr, e_a3;
  logic [1:0]  e_tnew;
  logic        e_valid;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .clr(clr), .en(en),
    .d_instr(d_instr), .d_pc(d_pc), .d_rs_data(d_rs_data), .d_rt_data(d_rt_data),
    .d_ext(d_ext), .d_a3(d_a3), .d_tnew(d_tnew),
    .e_instr(e_instr), .e_pc(e_pc), .e_pc8(e_pc8), .e_rs_data(e_rs_data),
    .e_rt_data(e_rt_data), .e_ext(e_ext), .e_rs_addr(e_rs_addr), .e_rt_addr(e_rt_addr),
    .e_a3(e_a3), .e_tnew(e_tnew),
`ifdef IDEX_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .e_valid(e_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, p, rs, rt, x, input logic [4:0] a3,
                       input logic [1:0] t);
    d_instr = i; d_pc = p; d_rs_data = rs; d_rt_data = rt; d_ext = x; d_a3 = a3; d_tnew = t;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; en = 1'b1;
    drive(32'hDEAD_BEEF, 32'h1234_5678, 32'h5, 32'h6, 32'h7, 5'd9, 2'd3);
    step();
    drive(32'hCAFE_F00D, 32'h8765_4321, 32'h8, 32'h9, 32'hA, 5'd7, 2'd2);
    step();
    chk("rst_pc",    e_pc,    32'h0000_3000);
    chk("rst_instr", e_instr, 32'h0);
    chk("rst_valid", e_valid, 32'h0);
    chk("rst_tnew",  e_tnew,  32'h0);
    chk("rst_a3",    e_a3,    32'h0);
    chk("rst_rs",    e_rs_data, 32'h0);
    chk("rst_pc8",   e_pc8,   32'h0000_3008);

    reset = 1'b0;
    drive(32'h3C01_1234, 32'h3004, 32'h1111_1111, 32'h2222_2222, 32'h0000_1234, 5'd1, 2'd2);
    step();
    chk("ld_instr",   e_instr,   32'h3C01_1234);
    chk("ld_pc",      e_pc,      32'h3004);
    chk("ld_rs",      e_rs_data, 32'h1111_1111);
    chk("ld_rt",      e_rt_data, 32'h2222_2222);
    chk("ld_ext",     e_ext,     32'h0000_1234);
    chk("ld_a3",      e_a3,      32'd1);
    chk("ld_rs_addr", e_rs_addr, 32'd0);
    chk("ld_rt_addr", e_rt_addr, 32'd1);
    chk("ld_tnew",    e_tnew,    32'd1);
    chk("ld_valid",   e_valid,   32'd1);
    chk("ld_pc8",     e_pc8,     32'h300C);

    d_tnew = 2'd0;
    step();
    chk("sat_tnew0", e_tnew, 32'd0);
    d_tnew = 2'd3;
    step();
    chk("sat_tnew3", e_tnew, 32'd2);

    drive(32'h8C22_0004, 32'h3008, 32'hAAAA_0000, 32'hBBBB_0000, 32'h4, 5'd2, 2'd3);
    step();
    chk("hld_rs_addr", e_rs_addr, 32'd1);
    chk("hld_rt_addr", e_rt_addr, 32'd2);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(32'h1000_0000 + k, 32'h4000 + 4 * k, 32'h77 + k, 32'h88 + k, 32'h99 + k,
            5'(20 + k), 2'(k));
      step();
      chk("hld_instr", e_instr,   32'h8C22_0004);
      chk("hld_pc",    e_pc,      32'h3008);
      chk("hld_rs",    e_rs_data, 32'hAAAA_0000);
      chk("hld_a3",    e_a3,      32'd2);
      chk("hld_tnew",  e_tnew,    32'd2);
      chk("hld_valid", e_valid,   32'd1);
    end

    clr = 1'b1; en = 1'b1;
    drive(32'h2402_0005, 32'h3010, 32'h55, 32'h66, 32'h5, 5'd5, 2'd2);
    step();
    chk("clr_instr", e_instr,   32'h0);
    chk("clr_a3",    e_a3,      32'h0);
    chk("clr_tnew",  e_tnew,    32'h0);
    chk("clr_valid", e_valid,   32'h0);
    chk("clr_pc",    e_pc,      32'h3010);
    chk("clr_rs",    e_rs_data, 32'h0);
    chk("clr_rsadr", e_rs_addr, 32'h0);
    chk("clr_rtadr", e_rt_addr, 32'h0);

    clr = 1'b0; en = 1'b0;
    drive(32'h1111_2222, 32'h5000, 32'h1, 32'h2, 32'h3, 5'd4, 2'd3);
    step();
    chk("bub_valid", e_valid, 32'h0);
    chk("bub_pc",    e_pc,    32'h3010);
    chk("bub_a3",    e_a3,    32'h0);

    reset = 1'b1; clr = 1'b1; en = 1'b1;
    step();
    chk("rstclr_pc",    e_pc,    32'h3000);
    chk("rstclr_valid", e_valid, 32'h0);

    reset = 1'b0; clr = 1'b0; en = 1'b1;
    drive(32'hFFFF_0000, 32'hFFFF_FFFC, 32'h3, 32'h4, 32'h5, 5'd31, 2'd1);
    step();
    chk("wrap_pc",   e_pc,   32'hFFFF_FFFC);
    chk("wrap_pc8",  e_pc8,  32'h0000_0004);
    chk("wrap_tnew", e_tnew, 32'h0);

    en = 1'b0; reset = 1'b1;
    step();
    chk("rsthld_instr", e_instr, 32'h0);
    chk("rsthld_pc",    e_pc,    32'h3000);
    chk("rsthld_a3",    e_a3,    32'h0);
    chk("rsthld_valid", e_valid, 32'h0);

`ifdef IDEX_BUBBLE_CNT_EN
    chk("cnt_rst", bubble_cnt, 32'h0);
    reset = 1'b0;
    clr = 1'b1; en = 1'b1;
    for (int k = 0; k < 5; k++) step();
    clr = 1'b0; en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("cnt_five", bubble_cnt, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
